// File: rtl/hub75_fb_memctl.sv
// hub75_fb_memctl: frame-buffer RAM shared by N clients through a round-robin
// req/gnt/rel arbiter. Writers target the back buffer, readers the front
// buffer; double or triple buffer rotation is synchronised to vsync.
module hub75_fb_memctl #(
    parameter int                   N_CLIENTS    = 2,
    parameter logic [N_CLIENTS-1:0] WR_MASK      = 'b01,
    parameter int                   AW           = 12,
    parameter int                   DW           = 16,
    parameter int                   N_FRAMES     = 2,
    parameter int                   LOG_N_FRAMES = $clog2(N_FRAMES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CLIENTS-1:0]    cl_req,
    output logic [N_CLIENTS-1:0]    cl_gnt,
    input  logic [N_CLIENTS-1:0]    cl_rel,
    input  logic [N_CLIENTS-1:0]    cl_en,
    input  logic [N_CLIENTS-1:0]    cl_we,
    input  logic [N_CLIENTS*AW-1:0] cl_addr,
    input  logic [N_CLIENTS*DW-1:0] cl_wdata,
    output logic [DW-1:0]           cl_rdata,
    output logic [N_CLIENTS-1:0]    cl_rvalid,
    input  logic                    frame_swap,
    input  logic                    frame_vsync,
    output logic                    frame_rdy,
    output logic                    swap_pending,
    output logic [LOG_N_FRAMES-1:0] front_idx,
    output logic [LOG_N_FRAMES-1:0] back_idx
);

    localparam int OW  = $clog2(N_CLIENTS);
    localparam int PAW = LOG_N_FRAMES + AW;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state;
    logic [OW-1:0]           owner, last, nxt, cand;
    logic                    found;
    logic                    own_en, own_we, own_wr;
    logic [AW-1:0]           own_addr;
    logic [DW-1:0]           own_wdata;
    logic [LOG_N_FRAMES-1:0] buf_idx;
    logic [PAW-1:0]          paddr;
    logic                    acc, wr_en, rd_en;
    logic [DW-1:0]           mem [0:(N_FRAMES<<AW)-1];

    // Round-robin pick: first requester strictly after the last owner
    always_comb begin
        nxt   = last;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_CLIENTS; k++) begin
            cand = OW'((int'(last) + k) % N_CLIENTS);
            if (!found && cl_req[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
    end

    // Arbiter FSM: grant in IDLE, hold until the owner releases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= '0;
            last   <= OW'(N_CLIENTS - 1);
            cl_gnt <= '0;
        end else begin
            case (state)
                IDLE: if (|cl_req) begin
                    owner  <= nxt;
                    cl_gnt <= N_CLIENTS'(1) << nxt;
                    state  <= BUSY;
                end
                BUSY: if (cl_rel[owner]) begin
                    cl_gnt <= '0;
                    last   <= owner;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Owner mux: only the granted client's strobes reach the RAM
    always_comb begin
        own_en    = 1'b0;
        own_we    = 1'b0;
        own_wr    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (owner == OW'(i)) begin
                own_en    = cl_en[i];
                own_we    = cl_we[i];
                own_wr    = WR_MASK[i];
                own_addr  = cl_addr[i*AW +: AW];
                own_wdata = cl_wdata[i*DW +: DW];
            end
        end
    end

    // Buffer is resolved per access, so index changes apply immediately
    assign buf_idx = own_wr ? back_idx : front_idx;
    assign paddr   = {buf_idx, own_addr};
    assign acc     = (state == BUSY) && own_en;
    assign wr_en   = acc && own_we;
    assign rd_en   = acc && !own_we;

    // RAM write port; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[paddr] <= own_wdata;
    end

    // Registered read data and per-client valid pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cl_rdata  <= '0;
            cl_rvalid <= '0;
        end else begin
            cl_rvalid <= rd_en ? (N_CLIENTS'(1) << owner) : '0;
            if (rd_en) cl_rdata <= mem[paddr];
        end
    end

    generate
        if (N_FRAMES == 3) begin : g_triple
            logic [LOG_N_FRAMES-1:0] ready_idx;

            assign frame_rdy = 1'b1;

            // Triple rotation: front/ready/back stay a permutation of {0,1,2}
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    front_idx    <= LOG_N_FRAMES'(0);
                    back_idx     <= LOG_N_FRAMES'(1);
                    ready_idx    <= LOG_N_FRAMES'(2);
                    swap_pending <= 1'b0;
                end else if (frame_swap && frame_vsync) begin
                    front_idx    <= back_idx;
                    ready_idx    <= front_idx;
                    back_idx     <= ready_idx;
                    swap_pending <= 1'b0;
                end else if (frame_swap) begin
                    // An older pending frame is dropped and replaced
                    back_idx     <= ready_idx;
                    ready_idx    <= back_idx;
                    swap_pending <= 1'b1;
                end else if (frame_vsync && swap_pending) begin
                    front_idx    <= ready_idx;
                    ready_idx    <= front_idx;
                    swap_pending <= 1'b0;
                end
            end
        end else begin : g_double
            logic p;

            assign p         = swap_pending | frame_swap;
            assign back_idx  = ~front_idx;
            assign frame_rdy = ~swap_pending;

            // Double buffering: flip front at vsync once a frame is complete
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    front_idx    <= '0;
                    swap_pending <= 1'b0;
                end else if (frame_vsync && p) begin
                    front_idx    <= ~front_idx;
                    swap_pending <= 1'b0;
                end else begin
                    swap_pending <= p;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_hub75_fb_memctl.sv
// Directed bench for hub75_fb_memctl: double-buffer instance with two clients
// (client 0 writer, client 1 reader) plus a triple-buffer instance for rotation.
module tb_hub75_fb_memctl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, rel, en, we, gnt, rvalid;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [15:0] rdata;
    logic        swap, vsync, rdy, pend;
    logic [0:0]  front, back;

    logic [1:0]  t_zero2, t_gnt, t_rvalid;
    logic [23:0] t_zero24;
    logic [31:0] t_zero32;
    logic [15:0] t_rdata;
    logic        t_swap, t_vsync, t_rdy, t_pend;
    logic [1:0]  t_front, t_back;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    hub75_fb_memctl #(.N_CLIENTS(2), .WR_MASK(2'b01), .AW(12), .DW(16), .N_FRAMES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .cl_req(req), .cl_gnt(gnt), .cl_rel(rel),
        .cl_en(en), .cl_we(we), .cl_addr(addr), .cl_wdata(wdata),
        .cl_rdata(rdata), .cl_rvalid(rvalid), .frame_swap(swap),
        .frame_vsync(vsync), .frame_rdy(rdy), .swap_pending(pend),
        .front_idx(front), .back_idx(back)
    );

    hub75_fb_memctl #(.N_CLIENTS(2), .WR_MASK(2'b01), .AW(12), .DW(16), .N_FRAMES(3)) u_tri (
        .clk(clk), .rst_n(rst_n), .cl_req(t_zero2), .cl_gnt(t_gnt), .cl_rel(t_zero2),
        .cl_en(t_zero2), .cl_we(t_zero2), .cl_addr(t_zero24), .cl_wdata(t_zero32),
        .cl_rdata(t_rdata), .cl_rvalid(t_rvalid), .frame_swap(t_swap),
        .frame_vsync(t_vsync), .frame_rdy(t_rdy), .swap_pending(t_pend),
        .front_idx(t_front), .back_idx(t_back)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        t_zero2 = '0; t_zero24 = '0; t_zero32 = '0;
        rst_n = 1'b0; req = '0; rel = '0; en = '0; we = '0; addr = '0; wdata = '0;
        swap = 1'b0; vsync = 1'b0; t_swap = 1'b0; t_vsync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",    32'(gnt), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_rdata",  32'(rdata), 32'h0);
        chk("rst_front",  32'(front), 32'h0);
        chk("rst_back",   32'(back), 32'h1);
        chk("rst_pend",   32'(pend), 32'h0);
        chk("rst_rdy",    32'(rdy), 32'h1);
        chk("rst_t_front", 32'(t_front), 32'h0);
        chk("rst_t_back",  32'(t_back), 32'h1);
        rst_n = 1'b1;

        // triple: swap+vsync together from reset -> front=1, ready=0, back=2
        t_swap = 1'b1; t_vsync = 1'b1; tick(); t_swap = 1'b0; t_vsync = 1'b0;
        chk("tri_both_front", 32'(t_front), 32'h1);
        chk("tri_both_back",  32'(t_back), 32'h2);
        chk("tri_both_pend",  32'(t_pend), 32'h0);
        chk("tri_rdy",        32'(t_rdy), 32'h1);

        // arbitration: both request, client 0 wins first
        req = 2'b11; tick();
        chk("arb_first", 32'(gnt), 32'h1);
        req = 2'b10; rel = 2'b01; tick(); rel = 2'b00;
        chk("arb_rel0", 32'(gnt), 32'h0);
        tick();
        chk("arb_next1", 32'(gnt), 32'h2);
        req = 2'b01; rel = 2'b10; tick(); rel = 2'b00;
        chk("arb_rel1", 32'(gnt), 32'h0);
        tick();
        chk("arb_rr0", 32'(gnt), 32'h1);
        req = 2'b00;

        // writer fills back buffer (buffer 1), then reads its own write next cycle
        en = 2'b01; we = 2'b01; addr[11:0] = 12'h010; wdata[15:0] = 16'hA5A5; tick();
        addr[11:0] = 12'h020; wdata[15:0] = 16'h1234; tick();
        we = 2'b00; tick();
        chk("wr_rd_next_data", 32'(rdata), 32'h1234);
        chk("wr_rd_next_vld",  32'(rvalid), 32'h1);
        en = 2'b00;

        // non-owner client 1 strobes a write: ignored
        en = 2'b10; we = 2'b10; addr[23:12] = 12'h020; wdata[31:16] = 16'hDEAD; tick();
        chk("nonowner_rvalid", 32'(rvalid), 32'h0);
        en = 2'b01; we = 2'b00; addr[11:0] = 12'h020; tick();
        chk("nonowner_word", 32'(rdata), 32'h1234);
        en = 2'b00;

        // hand bus to reader
        rel = 2'b01; req = 2'b10; tick(); rel = 2'b00; tick();
        chk("gnt_reader", 32'(gnt), 32'h2);
        req = 2'b00;

        // reader sees front buffer 0, not the writer's data
        en = 2'b10; addr[23:12] = 12'h010; tick();
        vecs++;
        assert (rdata !== 16'hA5A5) else begin
            errs++;
            $error("FAIL front_before_swap: observed %0h required not a5a5", rdata);
        end
        chk("front_rd_vld", 32'(rvalid), 32'h2);
        en = 2'b00; tick();
        chk("rvalid_pulse", 32'(rvalid), 32'h0);

        // double buffer swap handshake
        swap = 1'b1; tick(); swap = 1'b0;
        chk("swap_pend", 32'(pend), 32'h1);
        chk("swap_rdy",  32'(rdy), 32'h0);
        chk("swap_front_hold", 32'(front), 32'h0);
        swap = 1'b1; tick(); swap = 1'b0;
        chk("swap2_pend",  32'(pend), 32'h1);
        chk("swap2_front", 32'(front), 32'h0);
        vsync = 1'b1; tick(); vsync = 1'b0;
        chk("vsync_front", 32'(front), 32'h1);
        chk("vsync_back",  32'(back), 32'h0);
        chk("vsync_pend",  32'(pend), 32'h0);
        chk("vsync_rdy",   32'(rdy), 32'h1);

        // reader burst from new front buffer, one word per cycle
        en = 2'b10; addr[23:12] = 12'h010; tick();
        chk("burst0_data", 32'(rdata), 32'hA5A5);
        chk("burst0_vld",  32'(rvalid), 32'h2);
        addr[23:12] = 12'h020; tick();
        chk("burst1_data", 32'(rdata), 32'h1234);
        chk("burst1_vld",  32'(rvalid), 32'h2);
        addr[23:12] = 12'h010; tick();

        // asynchronous reset in the middle of the burst
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt",    32'(gnt), 32'h0);
        chk("mid_rst_rvalid", 32'(rvalid), 32'h0);
        chk("mid_rst_rdata",  32'(rdata), 32'h0);
        chk("mid_rst_front",  32'(front), 32'h0);
        chk("mid_rst_back",   32'(back), 32'h1);
        en = 2'b00;
        tick();
        rst_n = 1'b1; req = 2'b11; tick();
        chk("post_rst_gnt", 32'(gnt), 32'h1);
        req = 2'b00;

        // triple: two swaps then vsync; first completed frame is replaced
        t_swap = 1'b1; tick(); t_swap = 1'b0;
        chk("tri_s1_back",  32'(t_back), 32'h2);
        chk("tri_s1_pend",  32'(t_pend), 32'h1);
        chk("tri_s1_front", 32'(t_front), 32'h0);
        t_swap = 1'b1; tick(); t_swap = 1'b0;
        chk("tri_s2_back",  32'(t_back), 32'h1);
        t_vsync = 1'b1; tick(); t_vsync = 1'b0;
        chk("tri_v_front", 32'(t_front), 32'h2);
        chk("tri_v_back",  32'(t_back), 32'h1);
        chk("tri_v_pend",  32'(t_pend), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
